// File: rtl/uart_tx_sequencer.sv
// MMIO bus master that configures a UART and streams buffered bytes into its
// data-out register, polling the status register for TX-ready before each byte.
module uart_tx_sequencer #(
  parameter logic [2:0]  DEVICE_ADDRESS = 3'b011,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned POLL_LIMIT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic [15:0]                  cfg_cdiv,
  input  logic [7:0]                   cfg_cr,
  input  logic                         flush,
  input  logic [7:0]                   wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic [2:0]                   device_select,
  output logic [15:0]                  mmio_addr,
  output logic [7:0]                   mmio_data_out,
  input  logic [7:0]                   mmio_data_in,
  output logic                         mmio_wr,
  output logic                         mmio_rd,
  output logic                         configured,
  output logic                         busy,
  output logic                         timeout,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LEVEL_FULL = FIFO_DEPTH[AW:0];
  localparam logic [7:0]  POLL_LAST  = POLL_LIMIT[7:0];

  localparam logic [15:0] REG_CR     = 16'h0000;
  localparam logic [15:0] REG_SR     = 16'h0001;
  localparam logic [15:0] REG_CDIV_H = 16'h0002;
  localparam logic [15:0] REG_CDIV_L = 16'h0003;
  localparam logic [15:0] REG_DO     = 16'h0005;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_H, S_CFG_L, S_CFG_CR, S_READY, S_POLL_RD, S_POLL_WAIT, S_WRITE_DO
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    cdiv_l_q, cr_q, poll_cnt;
  logic          fifo_empty, push, pop, last_poll, tx_ready;
  logic          unused_sr_bits;

  assign tx_ready       = mmio_data_in[1];
  assign unused_sr_bits = ^{mmio_data_in[7:2], mmio_data_in[0]};
  assign fifo_empty     = (fifo_level == '0);
  assign wr_ready       = (fifo_level != LEVEL_FULL);
  assign busy           = (state != S_IDLE) && (state != S_READY);
  assign last_poll      = ((poll_cnt + 8'd1) == POLL_LAST);
  assign push           = wr_valid && wr_ready && !flush;
  assign pop            = !flush && ((state == S_WRITE_DO) ||
                          (state == S_POLL_WAIT && !tx_ready && last_poll));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Bus strobes are loaded on the edge that enters the state owning the access,
  // so each access is visible for exactly the cycle spent in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      device_select <= '0;
      mmio_addr     <= '0;
      mmio_data_out <= '0;
      mmio_wr       <= 1'b0;
      mmio_rd       <= 1'b0;
      configured    <= 1'b0;
      timeout       <= 1'b0;
      poll_cnt      <= '0;
      cdiv_l_q      <= '0;
      cr_q          <= '0;
    end else begin
      device_select <= '0;
      mmio_addr     <= '0;
      mmio_data_out <= '0;
      mmio_wr       <= 1'b0;
      mmio_rd       <= 1'b0;
      case (state)
        S_IDLE, S_READY: begin
          if (cfg_start) begin
            state         <= S_CFG_H;
            cdiv_l_q      <= cfg_cdiv[7:0];
            cr_q          <= cfg_cr | 8'h01;
            device_select <= DEVICE_ADDRESS;
            mmio_addr     <= REG_CDIV_H;
            mmio_data_out <= cfg_cdiv[15:8];
            mmio_wr       <= 1'b1;
          end else if (state == S_READY && !fifo_empty && !flush) begin
            state         <= S_POLL_RD;
            poll_cnt      <= '0;
            device_select <= DEVICE_ADDRESS;
            mmio_addr     <= REG_SR;
            mmio_rd       <= 1'b1;
          end
        end
        S_CFG_H: begin
          state         <= S_CFG_L;
          device_select <= DEVICE_ADDRESS;
          mmio_addr     <= REG_CDIV_L;
          mmio_data_out <= cdiv_l_q;
          mmio_wr       <= 1'b1;
        end
        S_CFG_L: begin
          state         <= S_CFG_CR;
          device_select <= DEVICE_ADDRESS;
          mmio_addr     <= REG_CR;
          mmio_data_out <= cr_q;
          mmio_wr       <= 1'b1;
        end
        S_CFG_CR: begin
          state      <= S_READY;
          configured <= 1'b1;
        end
        S_POLL_RD: begin
          state <= flush ? S_READY : S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (flush) begin
            state <= S_READY;
          end else if (tx_ready) begin
            state         <= S_WRITE_DO;
            device_select <= DEVICE_ADDRESS;
            mmio_addr     <= REG_DO;
            mmio_data_out <= mem[rd_ptr];
            mmio_wr       <= 1'b1;
          end else if (last_poll) begin
            state   <= S_READY;
            timeout <= 1'b1;
          end else begin
            state         <= S_POLL_RD;
            poll_cnt      <= poll_cnt + 8'd1;
            device_select <= DEVICE_ADDRESS;
            mmio_addr     <= REG_SR;
            mmio_rd       <= 1'b1;
          end
        end
        S_WRITE_DO: begin
          state <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: expected bus accesses are queued from a
// per-byte poll plan and compared by an independent negedge monitor.
module tb_uart_tx_sequencer;
  localparam int          LIMIT = 4;
  localparam int          DEPTH = 8;
  localparam logic [2:0]  DEV   = 3'b011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_cdiv = '0;
  logic [7:0]  cfg_cr = '0;
  logic        flush = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  device_select;
  logic [15:0] mmio_addr;
  logic [7:0]  mmio_data_out;
  logic [7:0]  mmio_data_in = '0;
  logic        mmio_wr, mmio_rd, configured, busy, timeout;
  logic [3:0]  fifo_level;

  uart_tx_sequencer #(.DEVICE_ADDRESS(DEV), .FIFO_DEPTH(DEPTH), .POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_cdiv(cfg_cdiv), .cfg_cr(cfg_cr),
    .flush(flush), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .device_select(device_select), .mmio_addr(mmio_addr), .mmio_data_out(mmio_data_out),
    .mmio_data_in(mmio_data_in), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .configured(configured), .busy(busy), .timeout(timeout), .fifo_level(fifo_level)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          gap;   // cycles since previous access; 0 = unchecked
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] sr_q[$];
  int  total = 0, bad = 0, cyc = 0;
  int  rd_cnt = 0, last_rd_cyc = -100, last_ev_cyc = -100;
  bit  timeout_exp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // UART status model: answers each read from the plan, random junk otherwise
  always @(posedge clk) begin
    logic [7:0] v;
    v = 8'($urandom);
    if (mmio_rd) v = (sr_q.size() != 0) ? sr_q.pop_front() : (v & 8'hFD);
    mmio_data_in <= v;
  end

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (rst) begin
      last_ev_cyc = -100;
    end else if (mmio_wr || mmio_rd) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_access: got wr=%0b rd=%0b addr=%h data=%h, want no access",
                 mmio_wr, mmio_rd, mmio_addr, mmio_data_out);
      end else begin
        e  = exp_q.pop_front();
        ok = (mmio_wr == e.wr) && (mmio_rd == !e.wr) && (mmio_addr == e.addr) &&
             (mmio_data_out == e.data) && (device_select == DEV) &&
             (e.gap == 0 || (cyc - last_ev_cyc) == e.gap);
        if (!ok) begin
          bad++;
          $display("FAIL bus_access: got wr=%0b rd=%0b addr=%h data=%h dev=%0d gap=%0d, want wr=%0b addr=%h data=%h dev=%0d gap=%0d",
                   mmio_wr, mmio_rd, mmio_addr, mmio_data_out, device_select, cyc - last_ev_cyc,
                   e.wr, e.addr, e.data, DEV, e.gap);
        end
      end
      if (mmio_rd) begin
        rd_cnt++;
        last_rd_cyc = cyc;
      end
      last_ev_cyc = cyc;
    end else begin
      total++;
      if (device_select != 3'b000 || mmio_addr != 16'h0 || mmio_data_out != 8'h00) begin
        bad++;
        $display("FAIL idle_bus: got dev=%0d addr=%h data=%h, want all zero",
                 device_select, mmio_addr, mmio_data_out);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // k = number of not-ready status reads the UART answers before ready
  task automatic plan_byte(input logic [7:0] b, input int k);
    int n = (k < LIMIT) ? k + 1 : LIMIT;
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, 16'h0001, 8'h00, (i == 0) ? 0 : 2});
    for (int i = 0; i < k && i < LIMIT; i++) sr_q.push_back(8'($urandom) & 8'hFD);
    if (k < LIMIT) begin
      sr_q.push_back(8'($urandom) | 8'h02);
      exp_q.push_back('{1'b1, 16'h0005, b, 2});
    end else begin
      timeout_exp = 1'b1;
    end
  endtask

  task automatic plan_cfg(input logic [15:0] cdiv, input logic [7:0] cr);
    exp_q.push_back('{1'b1, 16'h0002, cdiv[15:8], 0});
    exp_q.push_back('{1'b1, 16'h0003, cdiv[7:0], 1});
    exp_q.push_back('{1'b1, 16'h0000, cr | 8'h01, 1});
  endtask

  task automatic pulse_cfg(input logic [15:0] cdiv, input logic [7:0] cr);
    @(negedge clk);
    cfg_start = 1'b1; cfg_cdiv = cdiv; cfg_cr = cr;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int k);
    int n = 0;
    @(negedge clk);
    wr_data = b; wr_valid = 1'b1;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", 32'(n < 200), 32'd1);
    if (n < 200) plan_byte(b, k);
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || fifo_level != 0 || busy) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_drain"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fill [8];
    int ks [8] = '{0, 3, 0, 1, 2, 0, 1, 0};
    int acc;
    bit found;

    rst = 1'b1;
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_dev", device_select, 0);
    chk("rst_addr", mmio_addr, 0);
    chk("rst_dout", mmio_data_out, 0);
    chk("rst_wr", mmio_wr, 0);
    chk("rst_rd", mmio_rd, 0);
    chk("rst_configured", configured, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // fill past full while unconfigured
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      chk("fill_wr_ready", wr_ready, (i < DEPTH) ? 1 : 0);
      chk("fill_level", fifo_level, (i < DEPTH) ? i : DEPTH);
      if (i < DEPTH) fill[i] = wr_data;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("full_level", fifo_level, DEPTH);
    chk("full_wr_ready", wr_ready, 0);
    chk("idle_busy", busy, 0);

    plan_cfg(16'h1234, 8'h04);
    for (int i = 0; i < DEPTH; i++) plan_byte(fill[i], ks[i]);
    pulse_cfg(16'h1234, 8'h04);
    drain("cfg_fill");
    chk("configured", configured, 1);
    chk("timeout_after_slow_polls", timeout, 0);
    chk("drained_level", fifo_level, 0);
    chk("drained_wr_ready", wr_ready, 1);

    push_byte(8'h5A, LIMIT);
    push_byte(8'hC3, 0);
    drain("poll_limit");
    chk("timeout_set", timeout, 1);

    acc = 0;
    for (int c = 0; c < 3000 && acc < 40; c++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data  = 8'($urandom);
      if (wr_valid && wr_ready) begin
        plan_byte(wr_data, $urandom_range(0, 5));
        acc++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    drain("random");
    chk("timeout_random", timeout, 32'(timeout_exp));

    // flush while waiting on the first status sample of a 3-byte backlog
    exp_q.push_back('{1'b0, 16'h0001, 8'h00, 0});
    sr_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'(8'h10 + i);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      #1;
      if (rd_cnt > 0 && last_rd_cyc == cyc - 1 && !mmio_rd && !mmio_wr) begin
        flush = 1'b1;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("flush_window", 32'(found), 1);
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("flush_level", fifo_level, 0);
    chk("flush_busy", busy, 0);
    chk("flush_configured", configured, 1);
    chk("flush_no_do", exp_q.size(), 0);
    sr_q.delete();
    push_byte(8'h3C, 0);
    drain("after_flush");

    // reset mid-configuration, during the CDIV_L write
    exp_q.push_back('{1'b1, 16'h0002, 8'hAB, 0});
    @(negedge clk);
    cfg_start = 1'b1; cfg_cdiv = 16'hABCD; cfg_cr = 8'h80;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_wr", mmio_wr, 0);
    chk("arst_rd", mmio_rd, 0);
    chk("arst_dev", device_select, 0);
    chk("arst_addr", mmio_addr, 0);
    chk("arst_dout", mmio_data_out, 0);
    chk("arst_configured", configured, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Bus-master sequencer that drives the `uart` peripheral over the 8-bit MMIO bus so the CPU does not have to.
- Configures the UART clock divider and control register on command.
- Buffers outgoing bytes in a small FIFO.
- For each byte, polls the UART status register until the transmitter is ready, then writes the byte to the data-out register.

It sits between a byte producer (CPU store port or DMA) and the shared MMIO bus, and owns the bus while it is active.

## Interface
Parameters:
- `DEVICE_ADDRESS`, default 3'b011: device_select code of the target UART. Must not be 3'b000.
- `FIFO_DEPTH`, default 8: byte FIFO entries. Power of two, 2..64.
- `POLL_LIMIT`, default 255: maximum not-ready SR reads per byte before it is dropped. 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_start` in 1: one-cycle pulse; begins the configuration sequence.
- `cfg_cdiv` in 16: clock divider value, sampled on the accepted `cfg_start`.
- `cfg_cr` in 8: CR value, sampled on the accepted `cfg_start`. Bit0 (TXE) is forced to 1 when written.
- `flush` in 1: empties the FIFO.
- `wr_data` in 8: byte to transmit.
- `wr_valid` in 1: push request.
- `wr_ready` out 1: equals !full.
- `device_select` out 3: DEVICE_ADDRESS during a bus access, otherwise 3'b000.
- `mmio_addr` out 16: UART register offset. 0 when idle.
- `mmio_data_out` out 8: write data to the UART. 0 when idle.
- `mmio_data_in` in 8: read data from the UART, valid the cycle after `mmio_rd`.
- `mmio_wr` out 1: write strobe.
- `mmio_rd` out 1: read strobe.
- `configured` out 1: set when the CR write completes.
- `busy` out 1: state is not IDLE and not READY.
- `timeout` out 1: sticky; set when a byte is dropped after POLL_LIMIT.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of stored bytes.

## Operation
UART register map (offsets): CR 0x0000, SR 0x0001, CDIV_H 0x0002, CDIV_L 0x0003, DO 0x0005. TX-ready is SR bit1 = 1.

States and transitions:
- IDLE: `cfg_start` → CFG_H. Bytes may be pushed and are held.
- CFG_H: write CDIV_H = cdiv[15:8] → CFG_L.
- CFG_L: write CDIV_L = cdiv[7:0] → CFG_CR.
- CFG_CR: write CR = cfg_cr | 8'h01; set `configured` → READY.
- READY:
  - `cfg_start` → CFG_H. Has priority over FIFO work; FIFO contents are kept.
  - else FIFO non-empty → POLL_RD with poll_cnt = 0.
- POLL_RD: `mmio_rd`=1, addr 0x0001 → POLL_WAIT.
- POLL_WAIT: bus idle; sample `mmio_data_in`.
  - bit1 = 1 → WRITE_DO.
  - bit1 = 0 and poll_cnt+1 == POLL_LIMIT → pop and discard head, set `timeout` → READY.
  - otherwise poll_cnt++ → POLL_RD.
- WRITE_DO: `mmio_wr`=1, addr 0x0005, data = FIFO head; pop → READY.

Ignored inputs and FIFO rules:
- `cfg_start` is ignored in every state except IDLE and READY.
- poll_cnt is 8 bits and never wraps past POLL_LIMIT.
- FIFO is circular with read/write pointers that wrap modulo FIFO_DEPTH.
- A push occurs when `wr_valid` && `wr_ready`. A push and a pop in the same cycle leave the level unchanged.
- `flush` empties the FIFO and wins over a same-cycle push.
- If `flush` is asserted in POLL_RD or POLL_WAIT, the byte is abandoned and the state returns to READY with no DO write.
- If `flush` coincides with WRITE_DO, the write completes and the FIFO ends up empty.
- `timeout` clears only on `rst`.

## Timing
- Reset (asynchronous): state IDLE, FIFO empty.
  - Outputs: wr_ready=1, device_select=0, mmio_addr=0, mmio_data_out=0, mmio_wr=0, mmio_rd=0, configured=0, busy=0, timeout=0, fifo_level=0.
- All bus outputs are registered and are asserted for exactly one cycle per access. `device_select` is valid only while `mmio_wr` or `mmio_rd` is high.
- Configuration: the accepted `cfg_start` at edge N produces writes in cycles N+1, N+2 and N+3. `configured`=1 from cycle N+4.
- Byte latency with the UART ready on the first poll: READY with non-empty FIFO at cycle T gives rd at T+1, sample at T+2, write at T+3, READY at T+4. Throughput is 1 byte per 4 cycles, minimum.
- Each not-ready poll adds 2 cycles.
- `fifo_level` and `wr_ready` update the cycle after a push or pop.
- An `rst` assertion mid-access aborts it immediately, and the bus goes idle asynchronously.

## Test plan
- Reset, then `cfg_start` with cdiv=16'h1234, cr=8'h04 → writes (0x0002,0x12), (0x0003,0x34), (0x0000,0x05) on consecutive cycles, all with device_select=3'b011; `configured`=1.
- Configure, push 0xA5, UART model returns SR=0x02 → rd at 0x0001, then write (0x0005,0xA5) three cycles after READY; fifo_level 1→0.
- Model returns SR=0x00 three times, then 0x02 → 4 reads before the single DO write; `timeout` stays 0.
- POLL_LIMIT=4, SR stuck at 0x00 → exactly 4 reads, byte discarded, `timeout`=1, no DO write, next byte proceeds.
- Push 9 bytes with FIFO_DEPTH=8 while IDLE → wr_ready=0 after 8, fifo_level=8. Configure → 8 bytes written in order; wr_ready returns to 1.
- `flush` asserted during POLL_WAIT with 3 bytes queued → no DO write, fifo_level=0, state READY. `rst` asserted during CFG_L → bus idle immediately, configured=0.
